fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined lc3b core. It replaces the purely combinational forwarding selector by tracking its own shadow copy of the destination tags in the EX, MEM and WB stages. From those tags it generates per-source bypass selects for the instruction in EX, and a load-use stall for the instruction in decode. It also inserts bubbles, honours global freeze and flush, and keeps a saturating stall counter.

## Interface
Parameters:
- REG_W, 3: register tag width (lc3b_reg); register file depth is 2**REG_W.
- NUM_SRC, 2: source operands per instruction.
- ZERO_REG_EN, 0: when 1, tag 0 is a constant register; it is never forwarded and never stalls.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  reset, asynchronous and active-low.
- adv  in  1  pipeline advance; 0 = global freeze (e.g. cache miss).
- flush  in  1  kill the decode instruction (mispredict); sampled only when adv=1.
- dc_valid  in  1  decode slot holds an instruction.
- dc_we  in  1  decode instruction writes the register file.
- dc_is_load  in  1  decode instruction is a load (LDR/LDB/LDI).
- dc_dest  in  REG_W  decode destination tag.
- dc_src  in  NUM_SRC*REG_W  decode source tags; source i is at [i*REG_W +: REG_W].
- dc_src_used  in  NUM_SRC  source i is actually read.
- ex_src  in  NUM_SRC*REG_W  source tags of the EX instruction, from the ID/EX register.
- ex_src_used  in  NUM_SRC  EX source read flags.
- fwd_sel  out  2*NUM_SRC  per-source select; 00 = regfile/ID_EX, 10 = EX/MEM, 01 = MEM/WB.
- load_use_stall  out  1  hold PC/IF/ID and bubble EX.
- stall_cnt  out  CNT_W  number of inserted load-use bubbles, saturating.
- cnt_clr  in  1  synchronous clear of stall_cnt.

## Operation
- The shadow stages are EX, MEM and WB. Each holds {valid, we, is_load, dest}.
- A stage is a producer when valid & we, and dest is not (ZERO_REG_EN & dest==0).
- load_use_stall = dc_valid & EX producer & EX.is_load & (some i with dc_src_used[i] & dc_src[i]==EX.dest, excluding the zero tag when ZERO_REG_EN).
- Stage update at the rising edge of clk:
  - adv=0: all stages hold. stall_cnt holds.
  - adv=1, flush=1: EX becomes a bubble, MEM<=EX, WB<=MEM. Flush has priority over the stall, and no count is taken.
  - adv=1, load_use_stall=1: EX becomes a bubble, MEM<=EX, WB<=MEM, and stall_cnt increments (saturating at all-ones).
  - adv=1 otherwise: EX<=dc_*, with valid=dc_valid. MEM<=EX, WB<=MEM.
- fwd_sel for each source i (with ex_src_used[i]=1 and a non-zero tag when ZERO_REG_EN):
  - MEM producer and MEM.dest==ex_src[i]: 10. The newest value wins.
  - else WB producer and WB.dest==ex_src[i]: 01.
  - else: 00.
  - Every source is evaluated independently. Both sources may select the same stage.
- cnt_clr has priority over increment. Clear and increment in the same cycle gives 0.

## Timing
- On reset_n low, asynchronously: all stage valids are 0, stall_cnt=0, fwd_sel=0, and load_use_stall=0.
- fwd_sel and load_use_stall are combinational from the stage registers and the current inputs. There are no registered outputs apart from stall_cnt.
- Producer entering EX at edge N:
  - It is visible as 10 during cycle N+1.
  - It is visible as 01 during cycle N+2.
  - It gives 00 from N+3 onward; the regfile write has completed.
- A load followed by a dependent instruction costs exactly one bubble, after which the dependent instruction receives 01.
- load_use_stall stays asserted throughout a freeze (adv=0). Only one bubble is inserted, at the first adv=1 edge.
- If reset_n is deasserted mid-operation, all in-flight tags are discarded, and no forwarding or stall follows until new instructions are issued.

## Test plan
- ADD R1 then ADD R2,R1,R1 (adv=1) -> cycle after issue, fwd_sel=4'b1010; next cycle 4'b0101.
- ADD R1; ADD R1; ADD R3,R1 -> src0 gets 10 (MEM wins over WB), not 01.
- LDR R4; ADD R5,R4,R0 -> load_use_stall=1 for one cycle, stall_cnt=1, then fwd_sel src0=01.
- LDR R4 with adv=0 for 3 cycles, dependent in decode -> stall high all 3 cycles, one bubble on release, stall_cnt=1.
- ZERO_REG_EN=1, ADD R0 then ADD R2,R0 -> fwd_sel=0 and no stall. Flush with a stall pending -> bubble inserted, stall_cnt unchanged.
- Force stall_cnt to all-ones and stall again -> holds at all-ones. cnt_clr together with a stall -> 0. reset_n pulsed mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: shadow EX/MEM/WB destination tags driving bypass selects, load-use stall and a saturating stall counter
module fwd_hazard_unit #(
  parameter int REG_W       = 3,
  parameter int NUM_SRC     = 2,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     adv,
  input  logic                     flush,
  input  logic                     dc_valid,
  input  logic                     dc_we,
  input  logic                     dc_is_load,
  input  logic [REG_W-1:0]         dc_dest,
  input  logic [NUM_SRC*REG_W-1:0] dc_src,
  input  logic [NUM_SRC-1:0]       dc_src_used,
  input  logic [NUM_SRC*REG_W-1:0] ex_src,
  input  logic [NUM_SRC-1:0]       ex_src_used,
  output logic [2*NUM_SRC-1:0]     fwd_sel,
  output logic                     load_use_stall,
  output logic [CNT_W-1:0]         stall_cnt,
  input  logic                     cnt_clr
);
  typedef struct packed {
    logic             valid;
    logic             we;
    logic [REG_W-1:0] dest;
  } tag_t;
  tag_t ex, mem, wb;
  logic ex_load;
  logic ex_prod, mem_prod, wb_prod, bubble;
  logic [NUM_SRC-1:0] ld_hit;
  function automatic logic live(input logic [REG_W-1:0] t);
    return ZERO_REG_EN == 0 || t != '0;
  endfunction
  assign ex_prod  = ex.valid && ex.we && live(ex.dest);
  assign mem_prod = mem.valid && mem.we && live(mem.dest);
  assign wb_prod  = wb.valid && wb.we && live(wb.dest);
  assign load_use_stall = dc_valid && ex_prod && ex_load && |ld_hit;
  assign bubble = flush || load_use_stall;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_W-1:0] ds, es;
    assign ds = dc_src[i*REG_W +: REG_W];
    assign es = ex_src[i*REG_W +: REG_W];
    assign ld_hit[i] = dc_src_used[i] && live(ds) && ds == ex.dest;
    // MEM is checked first so the newest in-flight value wins
    assign fwd_sel[2*i +: 2] = !(ex_src_used[i] && live(es)) ? 2'b00 :
                               mem_prod && mem.dest == es ? 2'b10 :
                               wb_prod && wb.dest == es ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex        <= '0;
      ex_load   <= 1'b0;
      mem       <= '0;
      wb        <= '0;
      stall_cnt <= '0;
    end else begin
      if (adv) begin
        ex      <= bubble ? '0 : {dc_valid, dc_we, dc_dest};
        ex_load <= !bubble && dc_is_load;
        mem     <= ex;
        wb      <= mem;
      end
      stall_cnt <= cnt_clr ? '0 :
                   adv && !flush && load_use_stall && !(&stall_cnt) ? stall_cnt + CNT_W'(1) : stall_cnt;
    end
  end
endmodule
